datapath_pipe: RTL and testbench

Parametrised two-stage successor to the single-cycle register/ALU datapath.
- Stage E: accepts one decoded control word per cycle through a valid/ready handshake, reads the register file and computes the ALU result.
- Stage M: performs an optional external memory access over a req/ack handshake, then writes back.
- Adds forwarding, memory stalls, a configurable register count and data width, and a flag register with explicit load enable.

---
 rtl/datapath_pkg.sv | 29 ++
 rtl/datapath_pipe_if.sv | 49 ++++
 rtl/alu_core.sv | 56 +++++
 rtl/datapath_pipe.sv | 149 ++++++++++++++
 tb/tb_datapath_pipe.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_pkg.sv
// Shared constants for the pipelined datapath: ALU function codes,
// status_out bit positions and the flag register layout.
package datapath_pkg;

  localparam logic [3:0] FS_AND   = 4'd0;
  localparam logic [3:0] FS_OR    = 4'd1;
  localparam logic [3:0] FS_ADD   = 4'd2;
  localparam logic [3:0] FS_SUB   = 4'd3;
  localparam logic [3:0] FS_XOR   = 4'd4;
  localparam logic [3:0] FS_NOR   = 4'd5;
  localparam logic [3:0] FS_SHL   = 4'd6;
  localparam logic [3:0] FS_SHR   = 4'd7;
  localparam logic [3:0] FS_PASSB = 4'd8;

  // status_out = {V, C, Z, N, Z of the op currently in E}
  localparam int ST_EZ = 0;
  localparam int ST_N  = 1;
  localparam int ST_Z  = 2;
  localparam int ST_C  = 3;
  localparam int ST_V  = 4;

  typedef struct packed {
    logic v;
    logic c;
    logic z;
    logic n;
  } flags_t;

endpackage

// File: rtl/datapath_pipe_if.sv
// Control-word, memory and writeback bundle of datapath_pipe.
// slave = the datapath side, master = the environment (decoder, memory, observer).
interface datapath_pipe_if #(
  parameter int WIDTH = 64,
  parameter int NREG  = 32,
  parameter int AW    = 64
);
  localparam int RW = $clog2(NREG);

  logic             cw_valid;
  logic             cw_ready;
  logic [RW-1:0]    cw_da;
  logic [RW-1:0]    cw_sa;
  logic [RW-1:0]    cw_sb;
  logic [3:0]       cw_fs;
  logic [WIDTH-1:0] cw_k;
  logic             cw_selb;
  logic             cw_regw;
  logic             cw_memr;
  logic             cw_memw;
  logic             cw_sl;

  logic             mem_req;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;

  logic             wb_valid;
  logic [RW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic [4:0]       status_out;

  modport slave (
    input  cw_valid, cw_da, cw_sa, cw_sb, cw_fs, cw_k, cw_selb,
           cw_regw, cw_memr, cw_memw, cw_sl, mem_ack, mem_rdata,
    output cw_ready, mem_req, mem_we, mem_addr, mem_wdata,
           wb_valid, wb_addr, wb_data, status_out
  );

  modport master (
    output cw_valid, cw_da, cw_sa, cw_sb, cw_fs, cw_k, cw_selb,
           cw_regw, cw_memr, cw_memw, cw_sl, mem_ack, mem_rdata,
    input  cw_ready, mem_req, mem_we, mem_addr, mem_wdata,
           wb_valid, wb_addr, wb_data, status_out
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU of the E stage: result plus N/Z/C/V.
module alu_core
  import datapath_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_fs,
  output logic [WIDTH-1:0] o_result,
  output logic             o_n,
  output logic             o_z,
  output logic             o_c,
  output logic             o_v
);
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_dif;
  logic [SHW-1:0] w_sh;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_dif = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_sh  = i_b[SHW-1:0];

  // Function decode; carry and overflow are only produced by ADD and SUB
  always_comb begin
    o_result = {WIDTH{1'b0}};
    o_c      = 1'b0;
    o_v      = 1'b0;
    case (i_fs)
      FS_AND:   o_result = i_a & i_b;
      FS_OR:    o_result = i_a | i_b;
      FS_ADD: begin
        o_result = w_sum[WIDTH-1:0];
        o_c      = w_sum[WIDTH];
        o_v      = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      FS_SUB: begin
        o_result = w_dif[WIDTH-1:0];
        o_c      = w_dif[WIDTH];
        o_v      = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_dif[WIDTH-1] != i_a[WIDTH-1]);
      end
      FS_XOR:   o_result = i_a ^ i_b;
      FS_NOR:   o_result = ~(i_a | i_b);
      FS_SHL:   o_result = i_a << w_sh;
      FS_SHR:   o_result = i_a >> w_sh;
      FS_PASSB: o_result = i_b;
      default:  o_result = {WIDTH{1'b0}};
    endcase
  end

  assign o_n = o_result[WIDTH-1];
  assign o_z = (o_result == {WIDTH{1'b0}});

endmodule

// File: rtl/datapath_pipe.sv
// Two-stage register/ALU datapath: E (regfile read + ALU) and M (optional
// memory access over req/ack, then writeback), with writeback forwarding.
module datapath_pipe
  import datapath_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int NREG  = 32,
  parameter int AW    = 64
) (
  input  logic          clock,
  input  logic          reset,
  datapath_pipe_if.slave bus
);
  localparam int            RW   = $clog2(NREG);
  localparam logic [RW-1:0] ZREG = RW'(NREG - 1);

  logic [WIDTH-1:0] r_rf [NREG];

  logic             r_m_valid;
  logic [RW-1:0]    r_m_da;
  logic [WIDTH-1:0] r_m_bp;
  logic [WIDTH-1:0] r_m_res;
  logic             r_m_regw;
  logic             r_m_memr;
  logic             r_m_memw;
  flags_t           r_flags;

  logic             w_m_mem;
  logic             w_m_done;
  logic             w_ready;
  logic             w_accept;
  logic             w_wb_valid;
  logic [WIDTH-1:0] w_wb_data;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_bp;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_res;
  logic             w_n;
  logic             w_z;
  logic             w_c;
  logic             w_v;
  logic [4:0]       w_status;

  assign w_m_mem    = r_m_memr | r_m_memw;
  assign w_m_done   = r_m_valid && (!w_m_mem || bus.mem_ack);
  assign w_ready    = !r_m_valid || w_m_done;
  assign w_accept   = bus.cw_valid && w_ready;
  assign w_wb_valid = w_m_done && r_m_regw;
  // A combined read+write is a write, so only a pure read returns memory data
  assign w_wb_data  = (r_m_memr && !r_m_memw) ? bus.mem_rdata : r_m_res;

  // Operand fetch with zero register and forwarding of the retiring M result
  always_comb begin
    w_a  = {WIDTH{1'b0}};
    w_bp = {WIDTH{1'b0}};
    if (bus.cw_sa == ZREG) begin
      w_a = {WIDTH{1'b0}};
    end else if (w_wb_valid && (r_m_da == bus.cw_sa)) begin
      w_a = w_wb_data;
    end else begin
      w_a = r_rf[bus.cw_sa];
    end
    if (bus.cw_sb == ZREG) begin
      w_bp = {WIDTH{1'b0}};
    end else if (w_wb_valid && (r_m_da == bus.cw_sb)) begin
      w_bp = w_wb_data;
    end else begin
      w_bp = r_rf[bus.cw_sb];
    end
  end

  assign w_b = bus.cw_selb ? bus.cw_k : w_bp;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_fs     (bus.cw_fs),
    .o_result (w_res),
    .o_n      (w_n),
    .o_z      (w_z),
    .o_c      (w_c),
    .o_v      (w_v)
  );

  // M-stage pipeline register and flag register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_m_valid <= 1'b0;
      r_m_da    <= {RW{1'b0}};
      r_m_bp    <= {WIDTH{1'b0}};
      r_m_res   <= {WIDTH{1'b0}};
      r_m_regw  <= 1'b0;
      r_m_memr  <= 1'b0;
      r_m_memw  <= 1'b0;
      r_flags   <= 4'b0000;
    end else begin
      if (w_accept) begin
        r_m_valid <= 1'b1;
        r_m_da    <= bus.cw_da;
        r_m_bp    <= w_bp;
        r_m_res   <= w_res;
        r_m_regw  <= bus.cw_regw;
        r_m_memr  <= bus.cw_memr;
        r_m_memw  <= bus.cw_memw;
      end else if (w_m_done) begin
        r_m_valid <= 1'b0;
      end else begin
        r_m_valid <= r_m_valid;
      end
      if (w_accept && bus.cw_sl) begin
        r_flags <= {w_v, w_c, w_z, w_n};
      end else begin
        r_flags <= r_flags;
      end
    end
  end

  // Register file; the zero register is never written
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= {WIDTH{1'b0}};
      end
    end else if (w_wb_valid && (r_m_da != ZREG)) begin
      r_rf[r_m_da] <= w_wb_data;
    end
  end

  // Status word assembly
  always_comb begin
    w_status        = 5'b00000;
    w_status[ST_V]  = r_flags.v;
    w_status[ST_C]  = r_flags.c;
    w_status[ST_Z]  = r_flags.z;
    w_status[ST_N]  = r_flags.n;
    w_status[ST_EZ] = w_z;
  end

  assign bus.cw_ready   = w_ready;
  assign bus.mem_req    = r_m_valid && w_m_mem;
  assign bus.mem_we     = r_m_memw;
  assign bus.mem_addr   = r_m_res[AW-1:0];
  assign bus.mem_wdata  = r_m_bp;
  assign bus.wb_valid   = w_wb_valid;
  assign bus.wb_addr    = r_m_da;
  assign bus.wb_data    = w_wb_data;
  assign bus.status_out = w_status;

endmodule

// File: tb/tb_datapath_pipe.sv
// Directed bench for datapath_pipe: writebacks are predicted into a scoreboard
// queue when an op is issued and compared when wb_valid is observed.
module tb_datapath_pipe;
  import datapath_pkg::*;

  localparam int WIDTH = 64;
  localparam int NREG  = 32;
  localparam int AW    = 64;

  typedef struct packed {
    logic [4:0]  a;
    logic [63:0] d;
  } wb_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  wb_t  q[$];

  int          ack_delay = 0;
  int          req_cnt   = 0;
  logic [63:0] mem [logic [63:0]];

  always #5 clock = ~clock;

  datapath_pipe_if #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) bus ();

  datapath_pipe #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Memory responder: acks after ack_delay waiting cycles of an open request
  always @(negedge clock) begin
    if (bus.mem_req) begin
      if (req_cnt >= ack_delay) begin
        bus.mem_ack = 1'b1;
        req_cnt     = 0;
        if (bus.mem_we) begin
          mem[bus.mem_addr] = bus.mem_wdata;
          bus.mem_rdata     = 64'hBAD0_BAD0_BAD0_BAD0;
        end else begin
          bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 64'h0;
        end
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        req_cnt       = req_cnt + 1;
      end
    end else begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      req_cnt       = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [63:0] d);
    wb_t e;
    e.a = a;
    e.d = d;
    q.push_back(e);
  endtask

  task automatic wb_check();
    wb_t e;
    if (bus.wb_valid) begin
      if (q.size() == 0) begin
        chk("wb_unexpected", {59'd0, bus.wb_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("wb_addr", {59'd0, bus.wb_addr}, {59'd0, e.a});
        chk("wb_data", bus.wb_data, e.d);
      end
    end
  endtask

  task automatic cycle();
    #1;
    wb_check();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    bus.cw_valid = 1'b0;
    bus.cw_fs    = FS_PASSB;
    bus.cw_da    = 5'd31;
    bus.cw_sa    = 5'd31;
    bus.cw_sb    = 5'd31;
    bus.cw_k     = 64'd1;
    bus.cw_selb  = 1'b1;
    bus.cw_regw  = 1'b0;
    bus.cw_memr  = 1'b0;
    bus.cw_memw  = 1'b0;
    bus.cw_sl    = 1'b0;
  endtask

  task automatic set_op(input logic [3:0] fs, input logic [4:0] da, input logic [4:0] sa,
                        input logic [4:0] sb, input logic [63:0] k, input logic selb,
                        input logic regw, input logic memr, input logic memw, input logic sl);
    bus.cw_valid = 1'b1;
    bus.cw_fs    = fs;
    bus.cw_da    = da;
    bus.cw_sa    = sa;
    bus.cw_sb    = sb;
    bus.cw_k     = k;
    bus.cw_selb  = selb;
    bus.cw_regw  = regw;
    bus.cw_memr  = memr;
    bus.cw_memw  = memw;
    bus.cw_sl    = sl;
  endtask

  task automatic send(input logic [3:0] fs, input logic [4:0] da, input logic [4:0] sa,
                      input logic [4:0] sb, input logic [63:0] k, input logic selb,
                      input logic regw, input logic memr, input logic memw, input logic sl);
    logic acc;
    acc = 1'b0;
    set_op(fs, da, sa, sb, k, selb, regw, memr, memw, sl);
    for (int c = 0; c < 16 && !acc; c++) begin
      #1;
      acc = bus.cw_ready;
      wb_check();
      @(posedge clock);
      @(negedge clock);
    end
    chk("accepted", {63'd0, acc}, 64'd1);
  endtask

  task automatic status_idle(input string tag, input logic [4:0] exp);
    idle();
    #1;
    chk(tag, {59'd0, bus.status_out}, {59'd0, exp});
    wb_check();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // 1. reset behaviour, including dropping an open load
    #1;
    chk("rst_ready", {63'd0, bus.cw_ready}, 64'd1);
    chk("rst_status", {59'd0, bus.status_out}, 64'd0);
    chk("rst_wb_valid", {63'd0, bus.wb_valid}, 64'd0);
    @(negedge clock);
    ack_delay = 1000;
    set_op(FS_ADD, 5'd3, 5'd31, 5'd0, 64'h10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clock);
    @(negedge clock);
    idle();
    #1;
    chk("pre_rst_req", {63'd0, bus.mem_req}, 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_req", {63'd0, bus.mem_req}, 64'd0);
    chk("rst_mid_ready", {63'd0, bus.cw_ready}, 64'd1);
    chk("rst_mid_status", {59'd0, bus.status_out}, 64'd0);
    chk("rst_mid_wb", {63'd0, bus.wb_valid}, 64'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    ack_delay = 0;
    #1;
    chk("post_rst_req", {63'd0, bus.mem_req}, 64'd0);
    @(posedge clock);
    @(negedge clock);
    #1;
    chk("no_retry_req", {63'd0, bus.mem_req}, 64'd0);
    @(negedge clock);
    for (int i = 0; i < 31; i++) begin
      push(5'd31, 64'd0);
      send(FS_ADD, 5'd31, 5'(i), 5'd0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // 2. ADD then forwarded SUB with flag load
    push(5'd1, 64'd5);
    send(FS_ADD, 5'd1, 5'd31, 5'd0, 64'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push(5'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    send(FS_SUB, 5'd2, 5'd1, 5'd0, 64'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    status_idle("flags_sub", 5'b00010);

    // 3. signed overflow, then carry-out with zero result
    push(5'd5, 64'h7FFF_FFFF_FFFF_FFFF);
    send(FS_ADD, 5'd5, 5'd31, 5'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push(5'd6, 64'h8000_0000_0000_0000);
    send(FS_ADD, 5'd6, 5'd5, 5'd0, 64'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    status_idle("flags_ovf", 5'b10010);
    push(5'd7, 64'hFFFF_FFFF_FFFF_FFFF);
    send(FS_ADD, 5'd7, 5'd31, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push(5'd8, 64'd0);
    send(FS_ADD, 5'd8, 5'd7, 5'd0, 64'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    status_idle("flags_carry", 5'b01100);

    // 4. load with delayed ack and a dependent op waiting behind it
    mem[64'h10] = 64'hDEAD_BEEF_1234_5678;
    ack_delay = 2;
    push(5'd3, 64'hDEAD_BEEF_1234_5678);
    send(FS_ADD, 5'd3, 5'd31, 5'd0, 64'h10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    push(5'd4, 64'hDEAD_BEEF_1234_5679);
    set_op(FS_ADD, 5'd4, 5'd3, 5'd0, 64'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("ld_req", {63'd0, bus.mem_req}, 64'd1);
      chk("ld_addr", bus.mem_addr, 64'h10);
      chk("ld_we", {63'd0, bus.mem_we}, 64'd0);
      chk("ld_ready", {63'd0, bus.cw_ready}, (c == 2) ? 64'd1 : 64'd0);
      wb_check();
      @(posedge clock);
      @(negedge clock);
    end
    idle();
    ack_delay = 0;

    // 5. store acked in its first cycle, zero register write, read+write op
    send(FS_ADD, 5'd0, 5'd31, 5'd2, 64'h20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    push(5'd9, 64'd0);
    set_op(FS_ADD, 5'd9, 5'd2, 5'd0, 64'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("st_req", {63'd0, bus.mem_req}, 64'd1);
    chk("st_we", {63'd0, bus.mem_we}, 64'd1);
    chk("st_addr", bus.mem_addr, 64'h20);
    chk("st_wdata", bus.mem_wdata, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("st_ready", {63'd0, bus.cw_ready}, 64'd1);
    wb_check();
    @(posedge clock);
    @(negedge clock);
    chk("st_mem", mem[64'h20], 64'hFFFF_FFFF_FFFF_FFFE);
    push(5'd31, 64'h55);
    send(FS_ADD, 5'd31, 5'd31, 5'd0, 64'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push(5'd10, 64'd0);
    send(FS_ADD, 5'd10, 5'd31, 5'd0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push(5'd11, 64'h30);
    send(FS_ADD, 5'd11, 5'd31, 5'd1, 64'h30, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle();
    #1;
    chk("rw_req", {63'd0, bus.mem_req}, 64'd1);
    chk("rw_we", {63'd0, bus.mem_we}, 64'd1);
    wb_check();
    @(posedge clock);
    @(negedge clock);
    chk("rw_mem", mem[64'h30], 64'd5);

    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      cycle();
    end
    chk("sb_drained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
